// File: rtl/mux_nway_reg.sv
// N-channel WIDTH-bit registered multiplexer with valid/ready handshakes, fixed or round-robin selection.
// Optional transfer counter is built when MUX_NWAY_REG_COUNT_EN is defined; otherwise xfer_count is tied to 0.
module mux_nway_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH*CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          cur_sel,
  output logic [15:0]               xfer_count
);

  localparam logic [SEL_W:0] CH_W = (SEL_W+1)'(CHANNELS);

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [SEL_W-1:0] chosen_s;
  logic             chosen_ok_s;
  logic [SEL_W:0]   scan_idx_s;
  logic             load_ok_s;
  logic             in_xfer_s;
  logic [WIDTH-1:0] in_data_s;

  // Channel choice: fixed select, or first valid channel scanning from rr_ptr with wrap.
  always_comb begin
    chosen_s    = {SEL_W{1'b0}};
    chosen_ok_s = 1'b0;
    scan_idx_s  = {(SEL_W+1){1'b0}};
    if (mode == 1'b0) begin
      chosen_s    = sel;
      chosen_ok_s = ({1'b0, sel} < CH_W);
    end else begin
      // Walk the scan order backwards so the earliest valid channel is the last one written.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        scan_idx_s  = {1'b0, rr_ptr_q} + (SEL_W+1)'(i);
        scan_idx_s  = (scan_idx_s >= CH_W) ? (scan_idx_s - CH_W) : scan_idx_s;
        chosen_s    = in_valid[scan_idx_s[SEL_W-1:0]] ? scan_idx_s[SEL_W-1:0] : chosen_s;
        chosen_ok_s = chosen_ok_s | in_valid[scan_idx_s[SEL_W-1:0]];
      end
    end
  end

  // Ready decode and data steering for the chosen channel.
  always_comb begin
    load_ok_s = !out_valid_q || out_ready;
    in_data_s = {WIDTH{1'b0}};
    in_ready  = {CHANNELS{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      in_ready[k] = !reset && load_ok_s && chosen_ok_s && (chosen_s == SEL_W'(k));
      in_data_s   = (chosen_s == SEL_W'(k)) ? in[k*WIDTH +: WIDTH] : in_data_s;
    end
    in_xfer_s = |(in_ready & in_valid);
  end

  // Output slot next state: load replaces (even while draining), drain alone empties, else hold.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    cur_sel_d   = cur_sel_q;
    rr_ptr_d    = rr_ptr_q;
    if (in_xfer_s) begin
      out_d       = in_data_s;
      out_valid_d = 1'b1;
      cur_sel_d   = chosen_s;
      if (mode == 1'b1) begin
        rr_ptr_d = (({1'b0, chosen_s} + (SEL_W+1)'(1)) == CH_W) ? {SEL_W{1'b0}}
                                                                 : (chosen_s + SEL_W'(1));
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      cur_sel_q   <= {SEL_W{1'b0}};
      rr_ptr_q    <= {SEL_W{1'b0}};
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cur_sel_q   <= cur_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign cur_sel   = cur_sel_q;

`ifdef MUX_NWAY_REG_COUNT_EN
  logic [15:0] xfer_count_q, xfer_count_d;

  // Saturating count of output transfers.
  always_comb begin
    if (out_valid_q && out_ready && (xfer_count_q != 16'hFFFF)) begin
      xfer_count_d = xfer_count_q + 16'd1;
    end else begin
      xfer_count_d = xfer_count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count_q <= 16'h0000;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
`else
  assign xfer_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mux_nway_reg.sv
// Self-checking bench for mux_nway_reg: directed scenarios plus randomized traffic against a
// cycle-level reference model; a second 3-channel instance exercises the out-of-range select.
module tb_mux_nway_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_bus;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        mode;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  cur_sel;
  logic [15:0] xfer_count;

  logic [47:0] in3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [15:0] out3;
  logic        out_valid3;
  logic [1:0]  cur_sel3;
  logic [15:0] xfer_count3;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] dat [4];

  // reference model state
  logic [15:0] m_out;
  logic        m_valid;
  int          m_sel;
  int          m_ptr;
  int          m_cnt;

  always #5 clk = ~clk;

  mux_nway_reg #(.WIDTH(16), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .in(in_bus), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .cur_sel(cur_sel), .xfer_count(xfer_count)
  );

  mux_nway_reg #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .reset(reset), .in(in3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel(2'd3), .mode(1'b0), .out(out3), .out_valid(out_valid3), .out_ready(1'b1),
    .cur_sel(cur_sel3), .xfer_count(xfer_count3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check ready against the model, clock, update model, check outputs.
  task automatic step(input logic rst, input logic md, input logic [1:0] s,
                      input logic [3:0] v, input logic ordy);
    int          c;
    int          k;
    logic [3:0]  er;
    logic        lok;
    logic        acc;
    logic        oxf;
    int          exp_cnt;
    @(negedge clk);
    reset     = rst;
    mode      = md;
    sel       = s;
    in_valid  = v;
    out_ready = ordy;
    in_bus    = {dat[3], dat[2], dat[1], dat[0]};
    #1;
    lok = !m_valid || ordy;
    c   = -1;
    if (!md) begin
      c = int'(s);
    end else begin
      for (int i = 0; i < 4; i++) begin
        k = (m_ptr + i) % 4;
        if (c < 0 && v[k]) c = k;
      end
    end
    er  = (!rst && lok && c >= 0) ? 4'(1 << c) : 4'b0000;
    acc = (er & v) != 4'b0000;
    oxf = m_valid && ordy;
    chk("in_ready", {28'd0, in_ready}, {28'd0, er});
    chk("oor_ready", {29'd0, in_ready3}, 32'd0);
    @(posedge clk);
    #1;
    if (rst) begin
      m_out = 16'h0000; m_valid = 1'b0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (acc) begin
        m_out   = dat[c];
        m_valid = 1'b1;
        m_sel   = c;
        if (md) m_ptr = (c + 1) % 4;
      end else if (oxf) begin
        m_valid = 1'b0;
      end
      if (oxf && m_cnt < 65535) m_cnt++;
    end
`ifdef MUX_NWAY_REG_COUNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    chk("out", {16'd0, out}, {16'd0, m_out});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("cur_sel", {30'd0, cur_sel}, 32'(m_sel));
    chk("xfer_count", {16'd0, xfer_count}, 32'(exp_cnt));
    chk("oor_out_valid", {31'd0, out_valid3}, 32'd0);
  endtask

  initial begin
    m_out = 16'h0000; m_valid = 1'b0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    reset = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b0000; out_ready = 1'b0;
    in_bus = 64'd0; in3 = 48'h3333_2222_1111; in_valid3 = 3'b111;
    for (int i = 0; i < 4; i++) dat[i] = 16'h0000;

    step(1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    step(1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    chk("reset_out", {16'd0, out}, 32'd0);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_sel", {30'd0, cur_sel}, 32'd0);

    // fixed select of channel 2
    dat[2] = 16'hBEEF;
    step(1'b0, 1'b0, 2'd2, 4'b0100, 1'b1);
    chk("fixed_out", {16'd0, out}, 32'h0000BEEF);
    chk("fixed_valid", {31'd0, out_valid}, 32'd1);
    chk("fixed_sel", {30'd0, cur_sel}, 32'd2);

    // back-pressure: held word stays, no ready, then reload without a bubble
    dat[2] = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd2, 4'b0100, 1'b0);
      chk("stall_out", {16'd0, out}, 32'h0000BEEF);
    end
    step(1'b0, 1'b0, 2'd2, 4'b0100, 1'b1);
    chk("unstall_out", {16'd0, out}, 32'h00001234);
    chk("unstall_valid", {31'd0, out_valid}, 32'd1);

    // mid-stream reset discards the held word
    step(1'b1, 1'b0, 2'd2, 4'b0100, 1'b1);
    chk("midrst_out", {16'd0, out}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);

    // round-robin fairness with all channels valid
    for (int i = 0; i < 4; i++) dat[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1);
      chk("rr_sel", {30'd0, cur_sel}, 32'(i % 4));
      chk("rr_out", {16'd0, out}, 32'h1000 + 32'(i % 4));
    end

    // skip/wrap: take ch2 (pointer -> 3), then only ch1 valid wraps round to it (pointer -> 2)
    step(1'b0, 1'b1, 2'd0, 4'b0100, 1'b1);
    chk("skip_sel2", {30'd0, cur_sel}, 32'd2);
    step(1'b0, 1'b1, 2'd0, 4'b0010, 1'b1);
    chk("wrap_sel1", {30'd0, cur_sel}, 32'd1);
    step(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1);
    chk("ptr_after_wrap", {30'd0, cur_sel}, 32'd2);
    step(1'b0, 1'b1, 2'd0, 4'b0000, 1'b1);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    step(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1);
    chk("ptr_held", {30'd0, cur_sel}, 32'd3);

    // counter: five transfers after reset
    step(1'b1, 1'b0, 2'd0, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'd1, 4'b0010, 1'b1);
    step(1'b0, 1'b0, 2'd1, 4'b0000, 1'b1);
`ifdef MUX_NWAY_REG_COUNT_EN
    chk("count5", {16'd0, xfer_count}, 32'd5);
    for (int i = 0; i < 65537; i++) step(1'b0, 1'b0, 2'd1, 4'b0010, 1'b1);
    chk("count_sat", {16'd0, xfer_count}, 32'h0000FFFF);
`else
    chk("count_off", {16'd0, xfer_count}, 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < 4; j++) dat[j] = 16'($urandom);
      step(($urandom_range(0, 49) == 0), 1'($urandom), 2'($urandom), 4'($urandom),
           ($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_nway_reg.md
Name: mux_nway_reg

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with a registered output stage and a valid/ready handshake on every channel and on the output.
- Channel choice is either a fixed external select or an internal round-robin scan.
- Generalises the 1-bit 2:1 combinational mux to Hack-width datapaths feeding shared buses, for example several sources contending for one memory or ALU input.
- One output register, one cycle of latency, full throughput.

Parameters:
- WIDTH, 16: data width per channel, in bits (Hack word).
- CHANNELS, 4: number of input channels; legal range 2..2**SEL_W.
- SEL_W, 2: width of the select and pointer fields.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH*CHANNELS  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; combinational.
- sel  input  SEL_W  fixed-mode channel select.
- mode  input  1  0 = fixed select, 1 = round-robin.
- out  output  WIDTH  registered data.
- out_valid  output  1  out holds a transfer.
- out_ready  input  1  downstream accepts.
- cur_sel  output  SEL_W  channel that supplied the current out word.
- xfer_count  output  16  accepted output transfers (see Optional Feature).

Behaviour:
- Reset: reset=1 at a clock edge sets out=0, out_valid=0, cur_sel=0, the round-robin pointer rr_ptr=0 and xfer_count=0. This applies mid-transfer too; any held word is discarded. While reset=1, in_ready is all zeros.
- Output slot:
  - load_ok = !out_valid || out_ready (the slot is empty, or it is draining this cycle).
  - Output transfer = out_valid && out_ready.
- Chosen channel c:
  - mode=0: c = sel. If sel >= CHANNELS, no channel is chosen, in_ready is 0 and nothing loads.
  - mode=1: c = first k with in_valid[k]=1, scanning rr_ptr, rr_ptr+1, …, CHANNELS-1, 0, …, rr_ptr-1 (wrapping). If no channel is valid, nothing is chosen.
- in_ready[k] = load_ok && (k == c); at most one bit is set.
- Input transfer on channel c = in_valid[c] && in_ready[c]. At the next edge:
  - out <= in[c], out_valid <= 1, cur_sel <= c.
  - If mode=1, rr_ptr <= (c+1) wraps to 0 at CHANNELS.
- Latency: data accepted at edge N appears on out after edge N, so it is visible in cycle N+1.
- Simultaneous output and input transfer in one cycle: the new word replaces the old one; out_valid stays 1 and no bubble is inserted.
- Output transfer with no input transfer: out_valid <= 0. out keeps its last value.
- Stall (out_valid=1, out_ready=0): out, cur_sel and rr_ptr hold. in_ready is all zeros.
- Changing sel or mode while stalled does not affect the held word; the change applies to the next load only.
- rr_ptr advances only on an input transfer and only in mode 1. Fixed mode leaves rr_ptr untouched.
- Non-chosen channels' data and valid are ignored; this is lossless because those channels see in_ready=0.
- Selection and ready logic are combinational from registered state and the inputs. out_ready influences in_ready combinationally.

Optional Feature:
- Macro: MUX_NWAY_REG_COUNT_EN.
- Defined:
  - xfer_count increments by 1 on every output transfer and saturates at 16'hFFFF (no wrap).
  - It is cleared by reset.
- Undefined:
  - xfer_count is tied to 16'h0000 and no counter logic is built.
  - The port list is identical in both builds.

Test Plan:
- Reset then fixed select: mode=0, sel=2, in ch2=16'hBEEF, in_valid=4'b0100, out_ready=1. Required: in_ready=4'b0100, and the next cycle shows out=16'hBEEF, out_valid=1, cur_sel=2. Asserting reset mid-stream gives out=0 and out_valid=0 at the next edge.
- Back-pressure: hold out_ready=0 for 3 cycles with ch2 valid. Required: out stays 16'hBEEF and in_ready=0 throughout. Raise out_ready: the new word loads in the same cycle and out_valid never drops.
- Round-robin fairness: mode=1, in_valid=4'b1111 constant, data ch k = 16'h1000+k, out_ready=1. Required: cur_sel sequence 0,1,2,3,0,1 and out sequence 1000,1001,1002,1003,1000,…
- Round-robin skip/wrap: mode=1, rr_ptr=3, in_valid=4'b0010. Required: channel 1 is chosen, then rr_ptr=2. With in_valid=0, out_valid drops after the drain and rr_ptr is unchanged.
- Out-of-range select: CHANNELS=3, SEL_W=2, mode=0, sel=3, all valid. Required: in_ready=3'b000 and out_valid stays 0.
- Counter (MUX_NWAY_REG_COUNT_EN defined): 5 output transfers give xfer_count=5. Force 65537 transfers and xfer_count reads 16'hFFFF. With the macro undefined, xfer_count=0 always.
